// File: rtl/impulse_period_meter.sv
// impulse_period_meter
//   Receive side of the impulse link. Measures the clock-cycle distance
//   between successive rising edges of `impulse`, reports each period with
//   a one-cycle strobe, tracks the longest period since reset, flags loss of
//   the pulse stream, and drives an 8-bit wrapping edge count on `led`.
//
// Parameters:
//   PERIOD_W       width of period, period_max and the cycle counter
//   TIMEOUT_CYCLES cycles without a rising edge before timeout
//                  (2 <= TIMEOUT_CYCLES <= 2**PERIOD_W - 1)
//
// Ports:
//   clk           system clock, all logic on rising edge
//   rst           synchronous reset, active-high
//   impulse       pulse stream from the impulse generator
//   period        last measured period in cycles
//   period_valid  one-cycle strobe when period updates
//   period_max    largest period since reset
//   timeout       high while the pulse stream is considered lost
//   led           wrapping count of rising edges
//
// Build option:
//   IMPULSE_METER_SYNC_EN  when defined, impulse passes through a 2-flop
//                          synchronizer before edge detect (+2 cycles
//                          latency, period values unchanged).
module impulse_period_meter #(
    parameter int PERIOD_W       = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                impulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic [PERIOD_W-1:0] period_max,
    output logic                timeout,
    output logic [7:0]          led
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] TIMEOUT = 2'd2;

    localparam logic [PERIOD_W-1:0] TIMEOUT_VAL = PERIOD_W'(TIMEOUT_CYCLES);
    localparam logic [PERIOD_W-1:0] ONE         = PERIOD_W'(1);

    logic [1:0]          state;
    logic [PERIOD_W-1:0] cnt;
    logic                impulse_s;
    logic                impulse_d;
    logic                rise;

`ifdef IMPULSE_METER_SYNC_EN
    logic sync_0;
    logic sync_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= impulse;
            sync_1 <= sync_0;
        end
    end

    assign impulse_s = sync_1;
`else
    assign impulse_s = impulse;
`endif

    assign rise = impulse_s & ~impulse_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            impulse_d    <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            period_max   <= '0;
            timeout      <= 1'b0;
            led          <= '0;
        end else begin
            impulse_d    <= impulse_s;
            period_valid <= 1'b0;

            if (rise) begin
                led <= led + 8'd1;
                cnt <= ONE;
            end

            case (state)
                IDLE: begin
                    if (rise)
                        state <= MEASURE;
                end
                MEASURE: begin
                    // A rise coinciding with cnt == TIMEOUT_VAL is still a
                    // valid measurement, so rise is tested first.
                    if (rise) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        if (cnt > period_max)
                            period_max <= cnt;
                    end else if (cnt == TIMEOUT_VAL) begin
                        state   <= TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                TIMEOUT: begin
                    // First edge after a gap only restarts the measurement.
                    if (rise) begin
                        state   <= MEASURE;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_impulse_period_meter.sv
module tb_impulse_period_meter;

    localparam int PW = 16;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          impulse = 1'b0;
    logic [PW-1:0] period;
    logic          period_valid;
    logic [PW-1:0] period_max;
    logic          timeout;
    logic [7:0]    led;

    impulse_period_meter #(
        .PERIOD_W      (PW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .impulse     (impulse),
        .period      (period),
        .period_valid(period_valid),
        .period_max  (period_max),
        .timeout     (timeout),
        .led         (led)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    // Reference model: works on absolute cycle numbers of rising edges.
    int      cyc      = 0;
    bit      prev_lvl = 1'b0;
    bit      have_ref = 1'b0;
    int      last     = 0;
    int      m_period = 0;
    int      m_max    = 0;
    int      m_led    = 0;
    bit      e_valid  = 1'b0;
    bit      e_to     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic step(input bit imp, input bit r);
        bit rise;
        impulse = imp;
        rst     = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            prev_lvl = 1'b0;
            have_ref = 1'b0;
            m_period = 0;
            m_max    = 0;
            m_led    = 0;
            e_valid  = 1'b0;
            e_to     = 1'b0;
        end else begin
            rise     = imp && !prev_lvl;
            prev_lvl = imp;
            e_valid  = 1'b0;
            if (rise) begin
                m_led = (m_led + 1) % 256;
                if (have_ref && (cyc - last) <= TO) begin
                    m_period = cyc - last;
                    if (m_period > m_max) m_max = m_period;
                    e_valid = 1'b1;
                end
                have_ref = 1'b1;
                last     = cyc;
                e_to     = 1'b0;
            end else begin
                e_to = have_ref && ((cyc - last) >= TO);
            end
        end
        #1;
        chk("period",       32'(period),       32'(m_period));
        chk("period_valid", 32'(period_valid), 32'(e_valid));
        chk("period_max",   32'(period_max),   32'(m_max));
        chk("timeout",      32'(timeout),      32'(e_to));
        chk("led",          32'(led),          32'(m_led));
    endtask

    // High for `width` cycles, then low until `gap` cycles after the rise.
    task automatic pulse(input int gap, input int width);
        for (int i = 0; i < width; i++) step(1'b1, 1'b0);
        for (int i = width; i < gap; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with impulse toggling
        for (int i = 0; i < 3; i++) step(bit'(i % 2), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Steady stream, period 10
        for (int i = 0; i < 5; i++) pulse(10, 1);

        // Varying periods
        pulse(7, 1);
        pulse(25, 1);
        pulse(12, 1);

        // Silence long enough to time out, then recover
        pulse(10, 1);
        pulse(70, 1);
        pulse(10, 1);
        pulse(10, 1);

        // Boundary gaps around the timeout
        pulse(50, 1);
        pulse(51, 1);
        pulse(10, 1);
        pulse(10, 1);

        // Mid-operation reset
        pulse(4, 1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        pulse(10, 1);
        pulse(10, 1);
        pulse(10, 1);

        // Level held high counts once; back-to-back 1,0,1 pulses
        pulse(30, 20);
        for (int i = 0; i < 4; i++) pulse(2, 1);
        pulse(15, 1);

        // Randomized gaps and widths, including timeouts
        for (int i = 0; i < 60; i++) begin
            int gap;
            int width;
            gap   = int'($urandom_range(2, 60));
            width = int'($urandom_range(1, gap - 1));
            pulse(gap, width);
        end

        // Enough edges to wrap led past 255
        for (int i = 0; i < 220; i++) pulse(2, 1);
        for (int i = 0; i < 55; i++) step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
